// File: rtl/mc10_cas_pkg.sv
// Shared definitions for the MC-10 cassette playback generator: FSM encoding,
// half-period arithmetic and the counter width for the default clock/tone set.
package mc10_cas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } cas_state_t;

    function automatic int half_cnt(input int clk_hz, input int f_hz);
        return clk_hz / (2 * f_hz);
    endfunction

    function automatic int cnt_width(input int h);
        return $clog2(h + 1);
    endfunction

    localparam int CLK_HZ_DEF = 28_636_360;
    localparam int F0_HZ_DEF  = 1200;
    localparam int H0_DEF     = half_cnt(CLK_HZ_DEF, F0_HZ_DEF);
    localparam int CW         = cnt_width(H0_DEF);

endpackage

// File: rtl/mc10_cas_fifo.sv
// Byte FIFO between the loader and the playback FSM. The head entry is always
// presented on dout, so a pop and its data happen in the same cycle.
module mc10_cas_fifo #(
    parameter int AW = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       full,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [7:0]    mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr_ok, rd_ok;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign dout  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_sys) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mc10_cas_player.sv
// MC-10 cassette playback: buffers loader bytes and FSK-encodes them LSB first
// onto cin, one full tone cycle per bit (F1 for a 1, F0 for a 0).
module mc10_cas_player
    import mc10_cas_pkg::*;
#(
    parameter int CLK_HZ  = 28_636_360,
    parameter int F0_HZ   = 1200,
    parameter int F1_HZ   = 2400,
    parameter int FIFO_AW = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        play,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        cin,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] byte_count
);
    localparam int H0   = half_cnt(CLK_HZ, F0_HZ);
    localparam int H1   = half_cnt(CLK_HZ, F1_HZ);
    localparam int HMAX = (H0 > H1) ? H0 : H1;
    localparam int HCW  = cnt_width(HMAX);

    if (H0 < 2 || H1 < 2) begin : g_bad_half
        $error("mc10_cas_player: half-period count must be at least 2");
    end

    function automatic logic [HCW-1:0] half_m1(input logic b);
        return b ? HCW'(H1 - 1) : HCW'(H0 - 1);
    endfunction

    cas_state_t     state_q, state_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [7:0]     sr_q, sr_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [15:0]    byte_count_q, byte_count_d;
    logic           underrun_q, underrun_d;

    logic       fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    assign wr_ready = ~fifo_full;
    assign fifo_wr  = wr_valid & ~fifo_full;
    assign fifo_rd  = (state_q == ST_LOAD);

    mc10_cas_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .din     (wr_data),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .dout    (fifo_dout),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hc_q         <= '0;
            sr_q         <= '0;
            bit_idx_q    <= '0;
            byte_count_q <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hc_q         <= hc_d;
            sr_q         <= sr_d;
            bit_idx_q    <= bit_idx_d;
            byte_count_q <= byte_count_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hc_d         = hc_q;
        sr_d         = sr_q;
        bit_idx_d    = bit_idx_q;
        byte_count_d = byte_count_q;
        underrun_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play && !fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sr_d      = fifo_dout;
                bit_idx_d = '0;
                hc_d      = half_m1(fifo_dout[0]);
                state_d   = ST_HIGH;
            end
            ST_HIGH: begin
                if (hc_q == '0) begin
                    hc_d    = half_m1(sr_q[0]);
                    state_d = ST_LOW;
                end else begin
                    hc_d = hc_q - 1'b1;
                end
            end
            ST_LOW: begin
                if (hc_q != '0) begin
                    hc_d = hc_q - 1'b1;
                end else if (bit_idx_q != 3'd7) begin
                    sr_d      = {1'b0, sr_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    hc_d      = half_m1(sr_q[1]);
                    state_d   = ST_HIGH;
                end else begin
                    // Underrun is only flagged at a byte boundary, never from a standing IDLE.
                    byte_count_d = byte_count_q + 16'd1;
                    if (play && !fifo_empty) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d    = ST_IDLE;
                        underrun_d = play & fifo_empty;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cin        = (state_q == ST_HIGH);
    assign busy       = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign underrun   = underrun_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_mc10_cas_player.sv
// Directed bench for mc10_cas_player at CLK_HZ=48000 (H0=20, H1=10), FIFO depth 4.
// cin/busy/underrun are logged every falling edge and compared with hand-built waveforms.
module tb_mc10_cas_player;
    localparam int H0 = 20;
    localparam int H1 = 10;
    localparam int HIST = 16384;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready, cin, busy, underrun;
    logic [15:0] byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic cin_hist  [HIST];
    logic und_hist  [HIST];
    logic busy_hist [HIST];
    logic exp_q [$];

    mc10_cas_player #(
        .CLK_HZ  (48000),
        .F0_HZ   (1200),
        .F1_HZ   (2400),
        .FIFO_AW (2)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .play       (play),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .cin        (cin),
        .busy       (busy),
        .underrun   (underrun),
        .byte_count (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (cyc < HIST) begin
            cin_hist[cyc]  <= cin;
            und_hist[cyc]  <= underrun;
            busy_hist[cyc] <= busy;
        end
        cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    function automatic int count_hi(input int which, input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) begin
            if (which == 0 && cin_hist[i] === 1'b1) n++;
            if (which == 1 && und_hist[i] === 1'b1) n++;
            if (which == 2 && busy_hist[i] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic exp_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
    endtask

    task automatic exp_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            int h;
            h = b[i] ? H1 : H0;
            for (int k = 0; k < h; k++) exp_q.push_back(1'b1);
            for (int k = 0; k < h; k++) exp_q.push_back(1'b0);
        end
    endtask

    task automatic check_wave(input string tag, input int s);
        int mism = 0;
        wait_to(s + exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (cin_hist[s + i] !== exp_q[i]) mism++;
        end
        check_eq(tag, mism, 0);
    endtask

    task automatic push(input logic [7:0] b, output int s);
        @(posedge clk_sys);
        #1;
        wr_data  = b;
        wr_valid = 1'b1;
        for (int i = 0; i < 2000 && !wr_ready; i++) begin
            @(posedge clk_sys);
            #1;
        end
        s = cyc;
        check_eq("push_ready", wr_ready, 1);
        @(posedge clk_sys);
        #1;
        wr_valid = 1'b0;
        $display("push 0x%02h accepted, sample index %0d", b, s);
    endtask

    task automatic do_reset();
        @(posedge clk_sys);
        #1;
        reset_n  = 1'b0;
        play     = 1'b0;
        wr_valid = 1'b0;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int s, s2, tmp;
        logic [7:0] bytes4 [5];
        bytes4 = '{8'h01, 8'h80, 8'hC3, 8'h5A, 8'h7E};

        // 1. reset state, then release with play=1 and no data
        #12;
        check_eq("rst_cin", cin, 0);
        check_eq("rst_wr_ready", wr_ready, 1);
        check_eq("rst_byte_count", byte_count, 0);
        check_eq("rst_busy_underrun", {busy, underrun}, 0);
        play = 1'b1;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        s = cyc;
        wait_to(s + 30);
        check_eq("idle_no_underrun", count_hi(1, s, s + 30), 0);
        check_eq("idle_cin_low", count_hi(0, s, s + 30), 0);
        $display("test1 reset done");

        // 2. single byte 0x55
        push(8'h55, s);
        exp_q.delete();
        exp_zeros(3);
        exp_byte(8'h55);
        exp_zeros(5);
        check_wave("wave_55", s);
        check_eq("first_rise_55", {cin_hist[s + 2], cin_hist[s + 3]}, 2'b01);
        check_eq("busy_cycles_55", count_hi(2, s, s + exp_q.size()), 240);
        check_eq("underrun_55", count_hi(1, s, s + exp_q.size()), 1);
        check_eq("byte_count_55", byte_count, 1);
        $display("test2 single byte done");

        // 3. back-to-back 0x00, 0xFF
        do_reset();
        play = 1'b1;
        push(8'h00, s);
        push(8'hFF, tmp);
        exp_q.delete();
        exp_zeros(3);
        exp_byte(8'h00);
        exp_zeros(1);
        exp_byte(8'hFF);
        exp_zeros(5);
        check_wave("wave_00_ff", s);
        check_eq("underrun_00_ff", count_hi(1, s, s + exp_q.size()), 1);
        check_eq("byte_count_00_ff", byte_count, 2);
        $display("test3 back-to-back done");

        // 4. FIFO full with play=0, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) push(bytes4[i], tmp);
        @(posedge clk_sys);
        #1;
        wr_data  = bytes4[4];
        wr_valid = 1'b1;
        check_eq("full_ready_low", wr_ready, 0);
        repeat (5) @(posedge clk_sys);
        #1;
        check_eq("full_held", {wr_ready, cin, busy}, 0);
        play = 1'b1;
        s = cyc;
        @(posedge clk_sys);
        #1;
        check_eq("ready_in_load", wr_ready, 0);
        @(posedge clk_sys);
        #1;
        check_eq("ready_after_pop", wr_ready, 1);
        @(posedge clk_sys);
        #1;
        wr_valid = 1'b0;
        $display("push 0x%02h accepted after first pop", bytes4[4]);
        exp_q.delete();
        exp_zeros(2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) exp_zeros(1);
            exp_byte(bytes4[i]);
        end
        exp_zeros(5);
        check_wave("wave_fifo_order", s);
        check_eq("underrun_fifo", count_hi(1, s, s + exp_q.size()), 1);
        check_eq("byte_count_fifo", byte_count, 5);
        $display("test4 fifo full done");

        // 5. play dropped during bit 3 of 0xA5
        do_reset();
        play = 1'b1;
        push(8'hA5, s);
        push(8'h3C, tmp);
        exp_q.delete();
        exp_zeros(3);
        exp_byte(8'hA5);
        exp_zeros(30);
        wait_to(s + 90);
        play = 1'b0;
        check_wave("wave_a5_drop", s);
        check_eq("drop_no_underrun", count_hi(1, s, s + exp_q.size()), 0);
        check_eq("drop_idle", {cin, busy}, 0);
        check_eq("byte_count_drop", byte_count, 1);
        play = 1'b1;
        s2 = cyc;
        exp_q.delete();
        exp_zeros(2);
        exp_byte(8'h3C);
        exp_zeros(5);
        check_wave("wave_resume_3c", s2);
        check_eq("underrun_resume", count_hi(1, s2, s2 + exp_q.size()), 1);
        check_eq("byte_count_resume", byte_count, 2);
        $display("test5 play drop done");

        // 6. reset during HIGH of bit 4 of 0xF0
        do_reset();
        play = 1'b1;
        push(8'hF0, s);
        push(8'h33, tmp);
        wait_to(s + 3 + 4 * 2 * H0 + 3);
        check_eq("pre_abort_high", {cin, busy}, 2'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_cin_async", {cin, busy}, 0);
        check_eq("abort_byte_count", byte_count, 0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        s2 = cyc;
        wait_to(s2 + 60);
        check_eq("abort_fifo_flushed", count_hi(0, s2, s2 + 60), 0);
        check_eq("abort_wr_ready", wr_ready, 1);
        check_eq("abort_byte_count_after", byte_count, 0);
        $display("test6 reset abort done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
